// File: rtl/dsdmnist_seqctrl.sv
// dsdmnist_seqctrl: conditions the board start switch, steps the MNIST engine
// through a batch of IMG_CNT images and stores each class in the result buffer.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for the first start request after reset
// S_START | one-cycle start pulse to the engine for image idx
// S_WAIT  | engine busy; class is captured on its done pulse
// S_WRITE | one-cycle result buffer write for image idx
// S_DONE  | batch complete; done LED on, interrupt pulse, restartable
module dsdmnist_seqctrl #(
  parameter int IMG_CNT       = 10,
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int CLASS_W       = 4,
  parameter int BASE_ADDR     = 0,
  parameter int DEBOUNCE_CYC  = 16,
  parameter int INT_PULSE_CYC = 4,
  localparam int IDX_W        = (IMG_CNT > 1) ? $clog2(IMG_CNT) : 1
) (
  input  logic               i_CLK,
  input  logic               i_RST_n,
  input  logic               i_STARTSW,
  output logic               o_INFER_START,
  output logic [IDX_W-1:0]   o_INFER_IDX,
  input  logic               i_INFER_DONE,
  input  logic [CLASS_W-1:0] i_INFER_CLASS,
  output logic               o_ARMINT,
  output logic               o_DONELED,
  output logic               o_RESULTBUF_EN,
  output logic               o_RESULTBUF_WE,
  output logic [DATA_W-1:0]  o_RESULTBUF_DATA,
  output logic [ADDR_W-1:0]  o_RESULTBUF_ADDR
);

  localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int INT_W = $clog2(INT_PULSE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               sw_meta;
  logic               sw_sync;
  logic               deb_level;
  logic               deb_prev;
  logic [DEB_W-1:0]   deb_cnt;
  logic               start_req;
  logic [IDX_W-1:0]   idx;
  logic [INT_W-1:0]   int_cnt;
  logic               last_img;
  logic [ADDR_W-1:0]  base_addr;

  assign start_req   = deb_level & ~deb_prev;
  assign last_img    = (idx == IDX_W'(IMG_CNT - 1));
  assign base_addr   = ADDR_W'(BASE_ADDR);
  assign o_INFER_IDX = idx;

  // Two-flop synchroniser, then a level that only follows the synchronised
  // switch after DEBOUNCE_CYC consecutive differing cycles.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      sw_meta   <= 1'b0;
      sw_sync   <= 1'b0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sw_meta  <= i_STARTSW;
      sw_sync  <= sw_meta;
      deb_prev <= deb_level;
      if (sw_sync != deb_level) begin
        if (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1)) begin
          deb_level <= sw_sync;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt      = state;
    o_INFER_START  = 1'b0;
    o_RESULTBUF_EN = 1'b0;
    o_RESULTBUF_WE = 1'b0;
    o_DONELED      = 1'b0;
    o_ARMINT       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req) state_nxt = S_START;
      end
      S_START: begin
        o_INFER_START = 1'b1;
        state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        if (i_INFER_DONE) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        o_RESULTBUF_EN = 1'b1;
        o_RESULTBUF_WE = 1'b1;
        state_nxt      = last_img ? S_DONE : S_START;
      end
      S_DONE: begin
        o_DONELED = 1'b1;
        o_ARMINT  = (int_cnt != '0);
        if (start_req) state_nxt = S_START;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Image index, captured result word/address and interrupt pulse timer.
  // Address and data are loaded on the done pulse so they are stable for the
  // whole WRITE cycle and simply hold afterwards.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      idx              <= '0;
      int_cnt          <= '0;
      o_RESULTBUF_ADDR <= '0;
      o_RESULTBUF_DATA <= '0;
    end else begin
      if ((state == S_IDLE || state == S_DONE) && start_req) begin
        idx <= '0;
      end else if (state == S_WRITE && !last_img) begin
        idx <= idx + IDX_W'(1);
      end
      if (state == S_WAIT && i_INFER_DONE) begin
        o_RESULTBUF_ADDR <= base_addr + ADDR_W'(idx);
        o_RESULTBUF_DATA <= DATA_W'(i_INFER_CLASS);
      end
      if (state == S_WRITE) begin
        int_cnt <= INT_W'(INT_PULSE_CYC);
      end else if (state == S_DONE && int_cnt != '0) begin
        int_cnt <= int_cnt - INT_W'(1);
      end
    end
  end

endmodule

// File: doc/dsdmnist_seqctrl.md
# dsdmnist_seqctrl

Parametrised run sequencer between the board start switch and the MNIST inference engine. It conditions `i_STARTSW`, steps the engine through `IMG_CNT` images, and writes each classification result into the result buffer. On completion it raises the ARM interrupt and the done LED. It generalises the single-shot start/done path to multi-image batches with configurable buffer width, base address, debounce length and interrupt pulse length.

## Interface
- `IMG_CNT`, default 10: images per batch, at least 1.
- `ADDR_W`, default 8: result buffer address width.
- `DATA_W`, default 8: result buffer data width, at least `CLASS_W`.
- `CLASS_W`, default 4: engine class output width.
- `BASE_ADDR`, default 0: buffer address of image 0.
- `DEBOUNCE_CYC`, default 16: stable-level cycles required on the switch, at least 1.
- `INT_PULSE_CYC`, default 4: `o_ARMINT` high time, at least 1.

Ports:
- `i_CLK`  in  1  the single clock. All logic is on its rising edge.
- `i_RST_n`  in  1  synchronous, active-low reset.
- `i_STARTSW`  in  1  raw, asynchronous start switch.
- `o_INFER_START`  out  1  one-cycle start pulse to the engine.
- `o_INFER_IDX`  out  clog2(`IMG_CNT`), minimum 1  current image index.
- `i_INFER_DONE`  in  1  one-cycle done pulse from the engine.
- `i_INFER_CLASS`  in  `CLASS_W`  class result, valid with `i_INFER_DONE`.
- `o_ARMINT`  out  1  completion interrupt pulse.
- `o_DONELED`  out  1  batch-complete indicator.
- `o_RESULTBUF_EN`  out  1  buffer enable.
- `o_RESULTBUF_WE`  out  1  buffer write enable.
- `o_RESULTBUF_DATA`  out  `DATA_W`  result word.
- `o_RESULTBUF_ADDR`  out  `ADDR_W`  result address.

## Operation
**Switch conditioning**
- `i_STARTSW` passes through a 2-flop synchroniser.
- The debounced level changes only after the synchronised value has differed from it for `DEBOUNCE_CYC` consecutive cycles. Any bounce restarts the count.
- A start request is the rising edge of the debounced level.

**State machine**
- IDLE:
  - Start request: `idx` is set to 0, go to START.
- START:
  - `o_INFER_START` is 1 and `o_INFER_IDX` equals `idx`.
  - Go to WAIT next cycle.
- WAIT:
  - On `i_INFER_DONE`, latch `i_INFER_CLASS` and go to WRITE.
  - `i_INFER_DONE` is ignored in every other state.
- WRITE:
  - EN = WE = 1 for one cycle.
  - ADDR = `BASE_ADDR` + `idx`, truncated to `ADDR_W`, so it wraps modulo 2^`ADDR_W`.
  - DATA = zero-extended latched class.
  - If `idx` == `IMG_CNT`−1, go to DONE. Otherwise increment `idx` and go to START.
- DONE:
  - `o_DONELED` is 1 and stays 1.
  - `o_ARMINT` is 1 for the first `INT_PULSE_CYC` cycles in DONE.
  - Start request: clear `o_DONELED`, stop any remaining ARMINT pulse, set `idx` to 0, go to START.

**Rules**
- Start requests in START, WAIT or WRITE are dropped, not queued.
- Buffer EN and WE are 0 outside WRITE.
- DATA and ADDR hold their last values outside WRITE.

## Timing
**Reset**
- While `i_RST_n` is 0 at a clock edge:
  - State goes to IDLE.
  - All outputs, `idx`, synchroniser flops, debounced level and counters go to 0.
- This applies mid-run, including during WRITE or an ARMINT pulse; they are truncated on the next edge.
- After reset a switch already held high produces a start request once it has been debounced. This is intended power-on behaviour.

**Latency**
- Switch rising at edge t: the debounced level rises at t+2+`DEBOUNCE_CYC`, and `o_INFER_START` is high in the following cycle.
- `o_INFER_START` to first possible WRITE: 2 cycles, given DONE arrives in the first WAIT cycle.
- `i_INFER_DONE` sampled at edge e: WRITE is asserted in the cycle after e.
- WRITE of the last image at cycle w: `o_DONELED` and `o_ARMINT` are high from cycle w+1.
- Minimum per-image period: 3 cycles (START, WAIT, WRITE).

**Boundary cases**
- `i_INFER_DONE` in the same cycle as `o_INFER_START` is ignored. The engine must respond no earlier than the next cycle.
- `IMG_CNT` = 1: a single WRITE, then DONE.

## Test plan
- Reset mid-run: `IMG_CNT`=4; assert `i_RST_n`=0 during the third WAIT. Required: next edge has every output 0 and state IDLE; no further writes until a new start.
- Full batch: `IMG_CNT`=4, `BASE_ADDR`=0x10, `DEBOUNCE_CYC`=8; press switch; engine returns classes 3,7,0,9 with 5-cycle latency. Required:
  - Writes of (0x10,3), (0x11,7), (0x12,0), (0x13,9).
  - Each write has EN=WE=1 for exactly one cycle.
  - `o_ARMINT` high for 4 cycles, then `o_DONELED`=1.
- Bounce rejection: toggle switch high/low every 3 cycles for 40 cycles, then hold high. Required: exactly one `o_INFER_START`, 2+8 cycles after the final rise, plus 1 cycle.
- Ignored stimuli:
  - Second press during WAIT: dropped; still exactly 4 writes.
  - Spurious `i_INFER_DONE` in IDLE: produces no write.
- Restart from DONE: press again. Required: `o_DONELED` drops, ARMINT stops, and writes restart at address 0x10.
- Address wrap: `ADDR_W`=4, `BASE_ADDR`=14, `IMG_CNT`=4. Required: addresses 14,15,0,1.
